// File: rtl/demux1x2_stream_pkg.sv
// Shared types and default sizes for the 1-to-2 stream demultiplexer.
// Optional build macro: DEMUX1X2_CNT_EN (enables the per-output transfer counters).
package demux1x2_pkg;

    // Occupancy of a single-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Default data word width and counter width.
    localparam int DEMUX_WIDTH = 4;
    localparam int DEMUX_CNT_W = 8;

endpackage : demux1x2_pkg

// File: rtl/demux1x2_stream_if.sv
// Bundle of the producer-side and both consumer-side handshakes of the demux.
//
// Handshake rule for every channel: a word moves on a rising edge where
// valid=1 and ready=1 in the cycle before it. The sender holds valid and data
// (and in_sel on the input channel) stable while valid=1 and ready=0. ready
// may depend combinationally on the receiver state (and on in_sel for the
// input channel) but never on valid.
//
// The slave modport is the demux side; master is the environment side
// (producer plus both consumers). slot0_state/slot1_state expose the slot
// state machines for observation.
interface demux1x2_stream_if
    import demux1x2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic [CNT_W-1:0] out0_cnt;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] out1_cnt;

    slot_state_e      slot0_state;
    slot_state_e      slot1_state;

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_cnt,
        output out1_valid, out1_data, out1_cnt, slot0_state, slot1_state
    );

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_cnt,
        input  out1_valid, out1_data, out1_cnt, slot0_state, slot1_state
    );

endinterface : demux1x2_stream_if

// File: rtl/demux1x2_stream_slot.sv
// One-entry register slot feeding one output of the demux.
// Loads a word, presents it with valid until the consumer takes it, and
// (with DEMUX1X2_CNT_EN defined) counts completed output transfers.
module demux_slot
    import demux1x2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o,
    output slot_state_e      state_o
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q;

    // Slot state machine. A load into a FULL slot only arrives when the
    // consumer is taking the current word in the same cycle, so the slot
    // stays FULL with the new word and no bubble is inserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (load_i) begin
                        state_q <= SLOT_FULL;
                        data_q  <= data_i;
                    end
                end
                SLOT_FULL: begin
                    if (load_i) begin
                        data_q <= data_i;
                    end else if (ready_i) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign state_o = state_q;

`ifdef DEMUX1X2_CNT_EN
    logic             drain;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign drain = valid_o & ready_i;
    assign cnt_d = cnt_q + CNT_W'(1);

    // Completed-transfer counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (drain) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule : demux_slot

// File: rtl/demux1x2_stream.sv
// Registered 1-to-2 stream demultiplexer.
// Steers each accepted input word by in_sel into one of two independent
// single-entry output slots; a stalled output never blocks the other one.
// Optional build macro: DEMUX1X2_CNT_EN (live out0_cnt/out1_cnt counters;
// otherwise both counter outputs are tied to zero).
module demux1x2_stream
    import demux1x2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1x2_stream_if.slave  bus
);

    logic valid0;
    logic valid1;
    logic slot_free0;
    logic slot_free1;
    logic accept;
    logic load0;
    logic load1;

    // A slot can take a word when it is empty or is being drained this cycle.
    assign slot_free0 = !valid0 || bus.out0_ready;
    assign slot_free1 = !valid1 || bus.out1_ready;

    // Readiness follows only the selected slot, so the other slot's stall is invisible.
    assign bus.in_ready = bus.in_sel ? slot_free1 : slot_free0;

    assign accept = bus.in_valid && bus.in_ready;
    assign load0  = accept && !bus.in_sel;
    assign load1  = accept &&  bus.in_sel;

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load0),
        .data_i  (bus.in_data),
        .ready_i (bus.out0_ready),
        .valid_o (valid0),
        .data_o  (bus.out0_data),
        .cnt_o   (bus.out0_cnt),
        .state_o (bus.slot0_state)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load1),
        .data_i  (bus.in_data),
        .ready_i (bus.out1_ready),
        .valid_o (valid1),
        .data_o  (bus.out1_data),
        .cnt_o   (bus.out1_cnt),
        .state_o (bus.slot1_state)
    );

    assign bus.out0_valid = valid0;
    assign bus.out1_valid = valid1;

endmodule : demux1x2_stream

// File: tb/tb_demux1x2_stream.sv
// Self-checking bench for demux1x2_stream: directed scenarios followed by
// random traffic, all compared against a queue-based model of the two slots.
module tb_demux1x2_stream;
    import demux1x2_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux1x2_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux1x2_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic [WIDTH-1:0] last0 = '0;
    logic [WIDTH-1:0] last1 = '0;
    int cnt0 = 0;
    int cnt1 = 0;
    int accepts = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef DEMUX1X2_CNT_EN
        return 32'(c % (1 << CNT_W));
`else
        return (c == c) ? 32'd0 : 32'd0;
`endif
    endfunction

    // A destination can take a word if its one-deep buffer is empty or
    // its consumer removes the buffered word this cycle.
    function automatic logic model_ready(input logic sel, input logic r0, input logic r1);
        if (sel) return (exp_q1.size() == 0) || r1;
        return (exp_q0.size() == 0) || r0;
    endfunction

    task automatic compare_outputs();
        check("in_ready", 32'(bus.in_ready), 32'(model_ready(bus.in_sel, bus.out0_ready, bus.out1_ready)));
        check("out0_valid", 32'(bus.out0_valid), 32'(exp_q0.size() != 0));
        check("out0_data", 32'(bus.out0_data), 32'((exp_q0.size() != 0) ? exp_q0[0] : last0));
        check("out1_valid", 32'(bus.out1_valid), 32'(exp_q1.size() != 0));
        check("out1_data", 32'(bus.out1_data), 32'((exp_q1.size() != 0) ? exp_q1[0] : last1));
        check("out0_cnt", 32'(bus.out0_cnt), exp_cnt(cnt0));
        check("out1_cnt", 32'(bus.out1_cnt), exp_cnt(cnt1));
    endtask

    // One clock cycle: check outputs after inputs settle, then advance the model at the edge.
    task automatic step();
        logic v, s, r0, r1, rst, rdy;
        logic [WIDTH-1:0] d;
        #1;
        compare_outputs();
        v   = bus.in_valid;
        s   = bus.in_sel;
        d   = bus.in_data;
        r0  = bus.out0_ready;
        r1  = bus.out1_ready;
        rst = rst_n;
        rdy = model_ready(s, r0, r1);
        @(posedge clk);
        if (!rst) begin
            exp_q0.delete();
            exp_q1.delete();
            last0 = '0;
            last1 = '0;
            cnt0  = 0;
            cnt1  = 0;
        end else begin
            if (exp_q0.size() != 0 && r0) begin
                void'(exp_q0.pop_front());
                cnt0++;
            end
            if (exp_q1.size() != 0 && r1) begin
                void'(exp_q1.pop_front());
                cnt1++;
            end
            if (v && rdy) begin
                accepts++;
                if (s) begin
                    exp_q1.push_back(d);
                    last1 = d;
                end else begin
                    exp_q0.push_back(d);
                    last0 = d;
                end
            end
        end
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.in_sel     = s;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int c0;
        logic rv, rs;
        logic [WIDTH-1:0] rd;
        logic held;

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_sel     = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset and idle
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Two words, one per destination, consumers ready
        drive(1'b1, 4'h3, 1'b0, 1'b1, 1'b1);
        check("dir_out0_data", 32'(bus.out0_data), 32'h3);
        drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b1);
        check("dir_out1_data", 32'(bus.out1_data), 32'hA);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("dir_cnt0", 32'(bus.out0_cnt), exp_cnt(1));
        check("dir_cnt1", 32'(bus.out1_cnt), exp_cnt(1));

        // Output 0 stalled: second word waits, output 1 keeps flowing
        drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
            check("stall_in_ready", 32'(bus.in_ready), 32'h0);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b1);
        check("stall_out1_data", 32'(bus.out1_data), 32'h9);
        check("stall_out0_data", 32'(bus.out0_data), 32'h5);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h6, 1'b0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Streaming 16 words to output 1 with no bubbles
        a0 = accepts;
        c0 = cnt1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b1);
        end
        check("stream_accepts", 32'(accepts - a0), 32'd16);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("stream_cnt1", 32'(cnt1 - c0), 32'd16);

        // Reset while both slots hold words; consumers ready on the reset edge
        drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid0", 32'(bus.out0_valid), 32'h1);
        check("pre_rst_valid1", 32'(bus.out1_valid), 32'h1);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("post_rst_valid0", 32'(bus.out0_valid), 32'h0);
        check("post_rst_cnt0", 32'(bus.out0_cnt), 32'h0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // 256 transfers to output 0: counter wraps back to its start value
        c0 = cnt0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b1);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("wrap_cnt0", 32'(bus.out0_cnt), exp_cnt(c0 + 256));

        // Random traffic with random back-pressure
        held = 1'b0;
        rv = 1'b0;
        rs = 1'b0;
        rd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!held) begin
                rv = ($urandom_range(0, 3) != 0);
                rs = 1'($urandom_range(0, 1));
                rd = WIDTH'($urandom);
            end
            a0 = accepts;
            drive(rv, rd, rs, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
            held = rv && (accepts == a0);
        end
        // Drain everything
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_demux1x2_stream
